// File: rtl/burst_addr_path.sv
// burst_addr_path: deserializes burst length/start address, steps the burst
// address per beat, flags completion, and reserializes the current address.
//
// Ports:
//   clk, rst (async, active-low)
//   burst_len_sin, burst_len_en       : length shift-in
//   send_burst_len_data,
//   initial_burst_len_reg_en          : length register load strobe pair
//   addr_sin, initial_addr_en         : address shift-in / single-transfer addr
//   send_addr_data,
//   initial_addr_reg_wen              : start-address load strobe pair
//   counter_en, adder_en              : beat count / address increment enables
//   addr_PTS_out_en/_load/_send_data  : serializer enable, load, shift
//   addr_PTS_out_word_sel             : bits sent = (sel+1)*ADDR_W/4
//   addr_sel                          : 0 = addr_sin passthrough, 1 = serializer
//   stop_signal, addr_sout, cur_addr, burst_len, pts_busy : outputs
module burst_addr_path #(
  parameter int ADDR_W = 20,
  parameter int LEN_W  = 4,
  parameter int STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              burst_len_sin,
  input  logic              addr_sin,
  input  logic              burst_len_en,
  input  logic              send_burst_len_data,
  input  logic              initial_burst_len_reg_en,
  input  logic              initial_addr_en,
  input  logic              send_addr_data,
  input  logic              initial_addr_reg_wen,
  input  logic              counter_en,
  input  logic              adder_en,
  input  logic              addr_PTS_out_en,
  input  logic              addr_PTS_out_load,
  input  logic              addr_PTS_out_send_data,
  input  logic [1:0]        addr_PTS_out_word_sel,
  input  logic              addr_sel,
  output logic              stop_signal,
  output logic              addr_sout,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [LEN_W-1:0]  burst_len,
  output logic              pts_busy
);

  localparam int QW    = ADDR_W / 4;
  localparam int CNT_W = $clog2(ADDR_W + 1);

  logic [LEN_W-1:0]  len_sr_q, len_sr_d;
  logic [ADDR_W-1:0] addr_sr_q, addr_sr_d;
  logic [LEN_W-1:0]  burst_len_q, burst_len_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W:0]    beat_cnt_q, beat_cnt_d;
  logic              stop_q, stop_d;
  logic [ADDR_W-1:0] pts_sr_q, pts_sr_d;
  logic [CNT_W-1:0]  pts_cnt_q, pts_cnt_d;

  logic             len_load;
  logic             addr_load;
  logic             step;
  logic [LEN_W:0]   beat_nxt;
  logic             pts_load;
  logic             pts_shift;
  logic             pts_drive;
  logic [CNT_W-1:0] pts_len;

  assign len_load  = send_burst_len_data && initial_burst_len_reg_en;
  assign addr_load = send_addr_data && initial_addr_reg_wen;
  // Any load this cycle suppresses the step.
  assign step      = counter_en && !stop_q && !len_load && !addr_load;
  assign beat_nxt  = beat_cnt_q + (LEN_W+1)'(1);

  assign pts_load  = addr_PTS_out_en && addr_PTS_out_load;
  assign pts_drive = addr_PTS_out_en && addr_PTS_out_send_data
                     && (pts_cnt_q != '0);
  assign pts_shift = !pts_load && pts_drive;

  always_comb begin
    pts_len = CNT_W'(ADDR_W);
    case (addr_PTS_out_word_sel)
      2'd0:    pts_len = CNT_W'(QW);
      2'd1:    pts_len = CNT_W'(2 * QW);
      2'd2:    pts_len = CNT_W'(3 * QW);
      default: pts_len = CNT_W'(ADDR_W);
    endcase
  end

  always_comb begin
    len_sr_d    = len_sr_q;
    addr_sr_d   = addr_sr_q;
    burst_len_d = burst_len_q;
    cur_addr_d  = cur_addr_q;
    beat_cnt_d  = beat_cnt_q;
    stop_d      = stop_q;

    if (burst_len_en)
      len_sr_d = {len_sr_q[LEN_W-2:0], burst_len_sin};
    if (initial_addr_en)
      addr_sr_d = {addr_sr_q[ADDR_W-2:0], addr_sin};

    if (len_load) begin
      burst_len_d = len_sr_q;
      beat_cnt_d  = '0;
      stop_d      = (len_sr_q == '0);
    end
    if (addr_load) begin
      cur_addr_d = addr_sr_q;
      beat_cnt_d = '0;
    end

    if (step) begin
      beat_cnt_d = beat_nxt;
      if (adder_en)
        cur_addr_d = cur_addr_q + ADDR_W'(STRIDE);
      if (beat_nxt == {1'b0, burst_len_q})
        stop_d = 1'b1;
    end
  end

  always_comb begin
    pts_sr_d  = pts_sr_q;
    pts_cnt_d = pts_cnt_q;
    if (pts_load) begin
      // Captures cur_addr as held, ignoring any same-cycle update.
      pts_sr_d  = cur_addr_q;
      pts_cnt_d = pts_len;
    end else if (pts_shift) begin
      pts_sr_d  = {pts_sr_q[ADDR_W-2:0], 1'b0};
      pts_cnt_d = pts_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_sr_q    <= '0;
      addr_sr_q   <= '0;
      burst_len_q <= '0;
      cur_addr_q  <= '0;
      beat_cnt_q  <= '0;
      stop_q      <= 1'b0;
      pts_sr_q    <= '0;
      pts_cnt_q   <= '0;
    end else begin
      len_sr_q    <= len_sr_d;
      addr_sr_q   <= addr_sr_d;
      burst_len_q <= burst_len_d;
      cur_addr_q  <= cur_addr_d;
      beat_cnt_q  <= beat_cnt_d;
      stop_q      <= stop_d;
      pts_sr_q    <= pts_sr_d;
      pts_cnt_q   <= pts_cnt_d;
    end
  end

  assign stop_signal = stop_q;
  assign cur_addr    = cur_addr_q;
  assign burst_len   = burst_len_q;
  assign pts_busy    = (pts_cnt_q != '0);
  assign addr_sout   = addr_sel ? (pts_drive ? pts_sr_q[ADDR_W-1] : 1'b0)
                                : addr_sin;

endmodule

// File: tb/tb_burst_addr_path.sv
// tb_burst_addr_path: directed tests for burst_addr_path with
// hand-computed expectations.
module tb_burst_addr_path;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        burst_len_sin = 0, addr_sin = 0;
  logic        burst_len_en = 0, send_burst_len_data = 0;
  logic        initial_burst_len_reg_en = 0;
  logic        initial_addr_en = 0, send_addr_data = 0;
  logic        initial_addr_reg_wen = 0;
  logic        counter_en = 0, adder_en = 0;
  logic        pts_en = 0, pts_load = 0, pts_send = 0;
  logic [1:0]  word_sel = 0;
  logic        addr_sel = 0;
  logic        stop_signal, addr_sout, pts_busy;
  logic [19:0] cur_addr;
  logic [3:0]  burst_len;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  burst_addr_path dut (
    .clk(clk), .rst(rst),
    .burst_len_sin(burst_len_sin), .addr_sin(addr_sin),
    .burst_len_en(burst_len_en),
    .send_burst_len_data(send_burst_len_data),
    .initial_burst_len_reg_en(initial_burst_len_reg_en),
    .initial_addr_en(initial_addr_en),
    .send_addr_data(send_addr_data),
    .initial_addr_reg_wen(initial_addr_reg_wen),
    .counter_en(counter_en), .adder_en(adder_en),
    .addr_PTS_out_en(pts_en), .addr_PTS_out_load(pts_load),
    .addr_PTS_out_send_data(pts_send),
    .addr_PTS_out_word_sel(word_sel),
    .addr_sel(addr_sel),
    .stop_signal(stop_signal), .addr_sout(addr_sout),
    .cur_addr(cur_addr), .burst_len(burst_len), .pts_busy(pts_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_len(input logic [3:0] v);
    burst_len_en = 1;
    for (int i = 3; i >= 0; i--) begin
      burst_len_sin = v[i];
      tick();
    end
    burst_len_en = 0;
  endtask

  task automatic load_len();
    send_burst_len_data = 1;
    initial_burst_len_reg_en = 1;
    tick();
    send_burst_len_data = 0;
    initial_burst_len_reg_en = 0;
  endtask

  task automatic shift_addr(input logic [19:0] v);
    initial_addr_en = 1;
    for (int i = 19; i >= 0; i--) begin
      addr_sin = v[i];
      tick();
    end
    initial_addr_en = 0;
    addr_sin = 0;
  endtask

  task automatic load_addr();
    send_addr_data = 1;
    initial_addr_reg_wen = 1;
    tick();
    send_addr_data = 0;
    initial_addr_reg_wen = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    addr_sel = 0;
    addr_sin = 1;
    #2;
    tests++;
    if (stop_signal !== 1'b0 || pts_busy !== 1'b0 ||
        cur_addr !== 20'h0 || burst_len !== 4'h0) begin
      fails++;
      $display("FAIL reset_state stop=%b busy=%b addr=%h len=%h want 0",
               stop_signal, pts_busy, cur_addr, burst_len);
    end
    tests++;
    if (addr_sout !== 1'b1) begin
      fails++;
      $display("FAIL reset_mux sout=%b want 1", addr_sout);
    end
    addr_sin = 0;
    tick();
    rst = 1;
    tick();
  endtask

  task automatic test_load();
    shift_len(4'b0101);
    load_len();
    shift_addr(20'h12345);
    load_addr();
    tests++;
    if (burst_len !== 4'd5 || cur_addr !== 20'h12345 ||
        stop_signal !== 1'b0) begin
      fails++;
      $display("FAIL load len=%h addr=%h stop=%b want 5 12345 0",
               burst_len, cur_addr, stop_signal);
    end
  endtask

  task automatic test_step();
    logic [19:0] ea;
    counter_en = 1;
    adder_en = 1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      ea = (k <= 5) ? 20'h12345 + 20'(k) : 20'h1234A;
      tests++;
      if (cur_addr !== ea || stop_signal !== (k >= 5)) begin
        fails++;
        $display("FAIL step%0d addr=%h stop=%b want %h %b",
                 k, cur_addr, stop_signal, ea, (k >= 5));
      end
    end
    counter_en = 0;
    adder_en = 0;
  endtask

  task automatic test_wrap_zero();
    logic [19:0] ea [3];
    ea[0] = 20'h00000;
    ea[1] = 20'h00001;
    ea[2] = 20'h00001;
    shift_len(4'd2);
    load_len();
    shift_addr(20'hFFFFF);
    load_addr();
    counter_en = 1;
    adder_en = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (cur_addr !== ea[k] || stop_signal !== (k >= 1)) begin
        fails++;
        $display("FAIL wrap%0d addr=%h stop=%b want %h %b",
                 k, cur_addr, stop_signal, ea[k], (k >= 1));
      end
    end
    counter_en = 0;
    shift_len(4'd0);
    load_len();
    tests++;
    if (stop_signal !== 1'b1 || burst_len !== 4'd0) begin
      fails++;
      $display("FAIL zero_len stop=%b len=%h want 1 0",
               stop_signal, burst_len);
    end
    counter_en = 1;
    tick();
    tick();
    tests++;
    if (cur_addr !== 20'h00001 || stop_signal !== 1'b1) begin
      fails++;
      $display("FAIL zero_hold addr=%h stop=%b want 00001 1",
               cur_addr, stop_signal);
    end
    counter_en = 0;
    adder_en = 0;
  endtask

  task automatic test_serial();
    logic [19:0] pat;
    pat = 20'hA5F00;
    shift_addr(pat);
    load_addr();
    addr_sel = 1;
    pts_en = 1;
    pts_load = 1;
    word_sel = 2'd3;
    tick();
    pts_load = 0;
    tests++;
    if (pts_busy !== 1'b1 || addr_sout !== 1'b0) begin
      fails++;
      $display("FAIL pts_loaded busy=%b sout=%b want 1 0",
               pts_busy, addr_sout);
    end
    pts_send = 1;
    for (int i = 19; i >= 0; i--) begin
      #1;
      tests++;
      if (addr_sout !== pat[i]) begin
        fails++;
        $display("FAIL ser20_bit%0d got %b want %b", i, addr_sout, pat[i]);
      end
      tick();
    end
    tests++;
    if (pts_busy !== 1'b0 || addr_sout !== 1'b0) begin
      fails++;
      $display("FAIL ser20_end busy=%b sout=%b want 0 0",
               pts_busy, addr_sout);
    end
    pts_send = 0;
    pts_load = 1;
    word_sel = 2'd1;
    tick();
    pts_load = 0;
    pts_send = 1;
    for (int i = 19; i >= 10; i--) begin
      if (i == 14) begin
        pts_send = 0;
        tick();
        tick();
        tests++;
        if (addr_sout !== 1'b0 || pts_busy !== 1'b1) begin
          fails++;
          $display("FAIL ser_pause sout=%b busy=%b want 0 1",
                   addr_sout, pts_busy);
        end
        pts_send = 1;
      end
      #1;
      tests++;
      if (addr_sout !== pat[i]) begin
        fails++;
        $display("FAIL ser10_bit%0d got %b want %b", i, addr_sout, pat[i]);
      end
      tick();
    end
    tests++;
    if (pts_busy !== 1'b0) begin
      fails++;
      $display("FAIL ser10_end busy=%b want 0", pts_busy);
    end
    pts_send = 0;
    pts_en = 0;
  endtask

  task automatic test_mux();
    addr_sel = 0;
    addr_sin = 1;
    #1;
    tests++;
    if (addr_sout !== 1'b1) begin
      fails++;
      $display("FAIL mux_hi sout=%b want 1", addr_sout);
    end
    addr_sin = 0;
    #1;
    tests++;
    if (addr_sout !== 1'b0) begin
      fails++;
      $display("FAIL mux_lo sout=%b want 0", addr_sout);
    end
    tick();
  endtask

  task automatic test_priority();
    shift_len(4'd5);
    load_len();
    shift_addr(20'h00ABC);
    counter_en = 1;
    adder_en = 1;
    load_addr();
    tests++;
    if (cur_addr !== 20'h00ABC || stop_signal !== 1'b0) begin
      fails++;
      $display("FAIL prio_load addr=%h stop=%b want 00abc 0",
               cur_addr, stop_signal);
    end
    tick();
    tests++;
    if (cur_addr !== 20'h00ABD) begin
      fails++;
      $display("FAIL prio_step addr=%h want 00abd", cur_addr);
    end
    counter_en = 0;
    adder_en = 0;
  endtask

  task automatic test_reset_mid();
    addr_sel = 1;
    pts_en = 1;
    pts_load = 1;
    word_sel = 2'd3;
    tick();
    pts_load = 0;
    pts_send = 1;
    tick();
    tick();
    #2;
    rst = 0;
    #1;
    tests++;
    if (pts_busy !== 1'b0 || addr_sout !== 1'b0 || cur_addr !== 20'h0 ||
        burst_len !== 4'h0 || stop_signal !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid busy=%b sout=%b addr=%h len=%h stop=%b want 0",
               pts_busy, addr_sout, cur_addr, burst_len, stop_signal);
    end
    tick();
    rst = 1;
    tick();
    tick();
    tests++;
    if (pts_busy !== 1'b0 || addr_sout !== 1'b0) begin
      fails++;
      $display("FAIL rst_after busy=%b sout=%b want 0 0",
               pts_busy, addr_sout);
    end
    pts_send = 0;
    pts_en = 0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_step();
    test_wrap_zero();
    test_serial();
    test_mux();
    test_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
